// File: rtl/mini68k_prefetch.sv
// Mini68k instruction prefetch queue: fetches opcode words into a small ring buffer.
// Optional odd-address fault tracking is enabled with `define MINI68K_PREFETCH_ADDR_ERR_EN.
module mini68k_prefetch #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [15:0]       ir,
  output logic              ir_valid,
  input  logic              ir_consume,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              supervisor,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_fc,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              addr_err
);

  localparam int         PTR_W     = $clog2(DEPTH);
  localparam int         CNT_W     = PTR_W + 1;
  localparam logic [2:0] FC_USER   = 3'b010;
  localparam logic [2:0] FC_SUPER  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DISCARD} state_t;

  state_t            state, state_nxt;
  logic [15:0]       q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count, count_after;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic              push, pop, space, stop, issue;

  // Flush wins over push and pop; the registered update below resets the queue instead.
  assign pop          = ir_consume && (count != '0);
  assign push         = (state == S_BUSY) && mem_ack && !flush;
  assign count_after  = count + CNT_W'(push) - CNT_W'(pop);
  assign space        = count_after < CNT_W'(DEPTH);
  assign fetch_pc_nxt = flush ? {flush_pc[ADDR_W-1:1], 1'b0}
                      : push  ? fetch_pc + ADDR_W'(2)
                      :         fetch_pc;
  assign issue        = (state_nxt == S_BUSY) && ((state == S_IDLE) || mem_ack);

`ifdef MINI68K_PREFETCH_ADDR_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        addr_err <= 1'b0;
    else if (flush) addr_err <= flush_pc[0];
  end
  assign stop = addr_err;
`else
  logic unused_flush_lsb;
  assign unused_flush_lsb = flush_pc[0];
  assign addr_err         = 1'b0;
  assign stop             = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!flush && !stop && space) state_nxt = S_BUSY;
      S_BUSY: begin
        if (flush)        state_nxt = mem_ack ? S_IDLE : S_DISCARD;
        else if (mem_ack) state_nxt = space ? S_BUSY : S_IDLE;
      end
      S_DISCARD: if (mem_ack) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state != S_IDLE);
    ir_valid = (count != '0);
    ir       = ir_valid ? q_data[head] : '0;
    ir_pc    = ir_valid ? q_pc[head]   : '0;
  end

  // mem_addr/mem_fc only move when a new request is issued, so they hold through wait states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      mem_addr <= RESET_PC;
      mem_fc   <= FC_USER;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      if (issue) begin
        mem_addr <= fetch_pc_nxt;
        mem_fc   <= supervisor ? FC_SUPER : FC_USER;
      end
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        count <= count_after;
      end
    end
  end

  // NOTE: queue storage has no reset; ir/ir_pc are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= mem_rdata;
      q_pc[tail]   <= mem_addr;
    end
  end

endmodule
